pipe_ctrl: RTL and testbench

- Pipeline sequencer for the 4-stage CPU: IF, DOF, EX, WB.
- Sits beside the instruction decoder and consumes its decoded fields (rw, dr, sa, sb, bs, ps) for the DOF, EX and WB stages.
- Generates PC-update, pipeline-register enables, bubbles and flushes for four cases: data-hazard stalls, data-memory waits, taken branches/jumps, and HALT drain/resume.

---
 rtl/pipe_ctrl_pkg.sv | 59 +++++
 rtl/pipe_ctrl_if.sv | 65 ++++++
 rtl/pipe_ctrl_hazard_detect.sv | 40 ++++
 rtl/pipe_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the 4-stage pipeline sequencer: opcodes, branch selects,
// PC source selects and the sequencer state encoding.
// Pure declarations; no logic, no latency, no flow control.
package pipe_ctrl_pkg;

  // Instruction opcodes seen by the sequencer (DOF stage opcode field)
  localparam logic [6:0] OP_NOP  = 7'h00;
  localparam logic [6:0] OP_ADD  = 7'h02;
  localparam logic [6:0] OP_LD   = 7'h21;
  localparam logic [6:0] OP_ST   = 7'h01;
  localparam logic [6:0] OP_BZ   = 7'h60;
  localparam logic [6:0] OP_BNZ  = 7'h61;
  localparam logic [6:0] OP_JMR  = 7'h70;
  localparam logic [6:0] OP_JMP  = 7'h44;
  localparam logic [6:0] OP_JML  = 7'h0C;
  localparam logic [6:0] HALT_OP = 7'h7F;

  // Branch select carried by the EX stage
  localparam logic [1:0] BS_NONE = 2'b00;
  localparam logic [1:0] BS_COND = 2'b01;
  localparam logic [1:0] BS_REG  = 2'b10;
  localparam logic [1:0] BS_JMP  = 2'b11;

  // PC source select
  localparam logic [1:0] PCS_INC = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_REG = 2'b10;
  localparam logic [1:0] PCS_JMP = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  // PC source for a taken branch/jump with the given branch select
  function automatic logic [1:0] pc_sel_for(input logic [1:0] bs);
    case (bs)
      BS_COND: return PCS_BR;
      BS_REG:  return PCS_REG;
      BS_JMP:  return PCS_JMP;
      BS_NONE: return PCS_INC;
      default: return PCS_INC;
    endcase
  endfunction

  // True for opcodes that redirect or stop the instruction stream
  function automatic logic is_ctrl_op(input logic [6:0] op);
    return (op == OP_BZ) || (op == OP_BNZ) || (op == OP_JMR) ||
           (op == OP_JMP) || (op == OP_JML) || (op == HALT_OP);
  endfunction

  // True for opcodes that access data memory or only compute
  function automatic logic is_data_op(input logic [6:0] op);
    return (op == OP_LD) || (op == OP_ST) || (op == OP_ADD) || (op == OP_NOP);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of decoded stage fields into the sequencer and pipeline controls out of it.
// Wires only; no latency.
// No flow control of its own; the sequencer drives the stall/enable controls.
interface pipe_ctrl_if #(parameter int CNT_W = 16);
  import pipe_ctrl_pkg::*;

  // DOF stage
  logic             id_valid;
  logic [6:0]       id_opcode;
  logic [4:0]       id_sa;
  logic [4:0]       id_sb;
  logic             id_use_a;
  logic             id_use_b;
  // EX stage
  logic             ex_valid;
  logic             ex_rw;
  logic [4:0]       ex_dr;
  logic [1:0]       ex_bs;
  logic             ex_ps;
  logic             ex_zero;
  // WB stage
  logic             wb_valid;
  logic             wb_rw;
  logic [4:0]       wb_dr;
  // memory and halt release
  logic             mem_req;
  logic             mem_ack;
  logic             resume;
  // controls
  logic             pc_we;
  logic [1:0]       pc_sel;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exwb_we;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
`ifdef PIPE_CTRL_FWD_EN
  logic             fwd_a;
  logic             fwd_b;
`endif

  modport master (
    output id_valid, id_opcode, id_sa, id_sb, id_use_a, id_use_b,
    output ex_valid, ex_rw, ex_dr, ex_bs, ex_ps, ex_zero,
    output wb_valid, wb_rw, wb_dr, mem_req, mem_ack, resume,
`ifdef PIPE_CTRL_FWD_EN
    input  fwd_a, fwd_b,
`endif
    input  pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble, exwb_we,
    input  halted, stall_cycles
  );

  modport slave (
    input  id_valid, id_opcode, id_sa, id_sb, id_use_a, id_use_b,
    input  ex_valid, ex_rw, ex_dr, ex_bs, ex_ps, ex_zero,
    input  wb_valid, wb_rw, wb_dr, mem_req, mem_ack, resume,
`ifdef PIPE_CTRL_FWD_EN
    output fwd_a, fwd_b,
`endif
    output pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble, exwb_we,
    output halted, stall_cycles
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Read-after-write hazard check of DOF sources against EX/WB destinations (PIPE_CTRL_FWD_EN: WB matches forward).
// Purely combinational, zero latency.
// No flow control; the result feeds the sequencer's stall decision.
module pipe_ctrl_hazard_detect (
  input  logic       id_valid,
  input  logic       id_use_a,
  input  logic       id_use_b,
  input  logic [4:0] id_sa,
  input  logic [4:0] id_sb,
  input  logic       ex_valid,
  input  logic       ex_rw,
  input  logic [4:0] ex_dr,
  input  logic       wb_valid,
  input  logic       wb_rw,
  input  logic [4:0] wb_dr,
`ifdef PIPE_CTRL_FWD_EN
  output logic       fwd_a,
  output logic       fwd_b,
`endif
  output logic       hazard
);

  logic ex_a, ex_b, wb_a, wb_b;

  // Per-source match against each later stage; R0 is hard-wired zero so never conflicts
  always_comb begin
    ex_a = id_valid & id_use_a & (id_sa != 5'd0) & ex_valid & ex_rw & (ex_dr == id_sa);
    ex_b = id_valid & id_use_b & (id_sb != 5'd0) & ex_valid & ex_rw & (ex_dr == id_sb);
    wb_a = id_valid & id_use_a & (id_sa != 5'd0) & wb_valid & wb_rw & (wb_dr == id_sa);
    wb_b = id_valid & id_use_b & (id_sb != 5'd0) & wb_valid & wb_rw & (wb_dr == id_sb);
`ifdef PIPE_CTRL_FWD_EN
    hazard = ex_a | ex_b;
    fwd_a  = wb_a;
    fwd_b  = wb_b;
`else
    hazard = ex_a | ex_b | wb_a | wb_b;
`endif
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the IF/DOF/EX/WB core: PC update, stage enables, bubbles, flushes, HALT drain (PIPE_CTRL_FWD_EN adds WB forwarding).
// Controls are combinational from state and inputs (zero latency); halted and stall_cycles are registered.
// Memory waits freeze every stage enable until mem_ack; hazards hold IF/DOF and bubble EX.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  pif
);

  localparam int DW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

  state_t           state_q, state_n;
  logic [DW-1:0]    drain_q, drain_n;
  logic             halted_q;
  logic [CNT_W-1:0] stall_q;

  logic       hazard;
  logic       taken;
  logic       halt_in_dof;
  logic       mem_wait;
  logic       use_run;
  logic       pc_we;
  logic [1:0] pc_sel;
  logic       ifid_we;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       exwb_we;

  pipe_ctrl_hazard_detect u_hazard (
    .id_valid (pif.id_valid),
    .id_use_a (pif.id_use_a),
    .id_use_b (pif.id_use_b),
    .id_sa    (pif.id_sa),
    .id_sb    (pif.id_sb),
    .ex_valid (pif.ex_valid),
    .ex_rw    (pif.ex_rw),
    .ex_dr    (pif.ex_dr),
    .wb_valid (pif.wb_valid),
    .wb_rw    (pif.wb_rw),
    .wb_dr    (pif.wb_dr),
`ifdef PIPE_CTRL_FWD_EN
    .fwd_a    (pif.fwd_a),
    .fwd_b    (pif.fwd_b),
`endif
    .hazard   (hazard)
  );

  // Event decode; BZ (ps=0) branches on zero, BNZ (ps=1) on nonzero, bs[1] is unconditional
  always_comb begin
    taken = pif.ex_valid &
            (((pif.ex_bs == BS_COND) & (pif.ex_zero ^ pif.ex_ps)) | pif.ex_bs[1]);
    halt_in_dof = pif.id_valid & (pif.id_opcode == HALT_OP);
    mem_wait    = pif.mem_req & ~pif.mem_ack;
  end

  // Next state and Mealy controls; RUN rules also apply on the WAIT_MEM release cycle
  always_comb begin
    state_n     = state_q;
    drain_n     = drain_q;
    use_run     = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = PCS_INC;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exwb_we     = 1'b0;

    case (state_q)
      ST_RUN:      use_run = 1'b1;
      ST_WAIT_MEM: use_run = pif.mem_ack;
      ST_DRAIN: begin
        // A pending memory op freezes the drain without consuming a cycle
        if (!mem_wait) begin
          idex_bubble = 1'b1;
          exwb_we     = 1'b1;
          if (drain_q <= DW'(1)) begin
            drain_n = '0;
            state_n = ST_HALTED;
          end else begin
            drain_n = drain_q - DW'(1);
          end
        end
      end
      ST_HALTED: begin
        if (pif.resume) state_n = ST_RUN;
      end
      default: state_n = ST_RUN;
    endcase

    if (use_run) begin
      state_n = ST_RUN;
      if (mem_wait) begin
        state_n = ST_WAIT_MEM;
      end else if (taken) begin
        // Redirect wins over anything in DOF: wrong-path IF/DOF contents are discarded
        pc_we       = 1'b1;
        pc_sel      = pc_sel_for(pif.ex_bs);
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        exwb_we     = 1'b1;
      end else if (halt_in_dof) begin
        // HALT moves on into EX; fetch stops while older work drains
        exwb_we = 1'b1;
        state_n = ST_DRAIN;
        drain_n = DW'(DRAIN_CYC);
      end else if (hazard) begin
        idex_bubble = 1'b1;
        exwb_we     = 1'b1;
      end else begin
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        exwb_we = 1'b1;
      end
    end
  end

  // State, drain counter, halted flag and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      drain_q  <= '0;
      halted_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_n;
      drain_q  <= drain_n;
      halted_q <= (state_n == ST_HALTED);
      if ((state_q != ST_HALTED) && !pc_we && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign pif.pc_we        = pc_we;
  assign pif.pc_sel       = pc_sel;
  assign pif.ifid_we      = ifid_we;
  assign pif.ifid_flush   = ifid_flush;
  assign pif.idex_bubble  = idex_bubble;
  assign pif.exwb_we      = exwb_we;
  assign pif.halted       = halted_q;
  assign pif.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle expectations go into a scoreboard queue,
// a negedge monitor pops and compares the control vector under a care mask.
// Vector layout: {pc_we, pc_sel[1:0], ifid_we, ifid_flush, idex_bubble, exwb_we, halted, stall[15:0]}.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(16)) pif ();

  pipe_ctrl #(.CNT_W(16), .DRAIN_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .pif (pif)
  );

`ifdef PIPE_CTRL_FWD_EN
  localparam int WS = 0;
`else
  localparam int WS = 1;
`endif
  // Stall totals at checkpoints: after hazards, after memory wait, after HALT drain
  localparam int S1 = 1 + WS;
  localparam int S2 = S1 + 1;
  localparam int S3 = S2 + 3;
  localparam int S4 = S3 + 3;

  localparam logic [23:0] M_ALL = 24'hFFFFFF;
  localparam logic [23:0] M_TK  = 24'hEDFFFF;  // ignore ifid_we, exwb_we
  localparam logic [23:0] M_FZ  = 24'hF3FFFF;  // ignore flush, bubble
  localparam logic [23:0] M_HLT = 24'hFDFFFF;  // ignore exwb_we
  localparam logic [23:0] M_DR  = 24'hF5FFFF;  // ignore flush, exwb_we

  typedef struct {
    string       name;
    logic [23:0] val;
    logic [23:0] mask;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  logic fin   = 1'b0;

  function automatic logic [23:0] mk(input logic we, input logic [1:0] sel, input logic ifd,
                                     input logic fl, input logic bub, input logic ew,
                                     input logic h, input int sc);
    return {we, sel, ifd, fl, bub, ew, h, 16'(sc)};
  endfunction

  function automatic logic [23:0] norm(input int sc);
    return mk(1'b1, PCS_INC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, sc);
  endfunction

  function automatic logic [23:0] hzd(input int sc);
    return mk(1'b0, PCS_INC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, sc);
  endfunction

  function automatic logic [23:0] tkn(input logic [1:0] sel, input int sc);
    return mk(1'b1, sel, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, sc);
  endfunction

  function automatic logic [23:0] frz(input logic h, input int sc);
    return mk(1'b0, PCS_INC, 1'b0, 1'b0, 1'b0, 1'b0, h, sc);
  endfunction

  task automatic chk(input string n, input logic [23:0] v, input logic [23:0] m);
    exp_t e;
    e.name = n;
    e.val  = v;
    e.mask = m;
    sb_q.push_back(e);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pif.id_valid = 1'b0; pif.id_opcode = OP_NOP; pif.id_sa = 5'd0; pif.id_sb = 5'd0;
    pif.id_use_a = 1'b0; pif.id_use_b = 1'b0;
    pif.ex_valid = 1'b0; pif.ex_rw = 1'b0; pif.ex_dr = 5'd0;
    pif.ex_bs = BS_NONE; pif.ex_ps = 1'b0; pif.ex_zero = 1'b0;
    pif.wb_valid = 1'b0; pif.wb_rw = 1'b0; pif.wb_dr = 5'd0;
    pif.mem_req = 1'b0; pif.mem_ack = 1'b0; pif.resume = 1'b0;
  endtask

  // Monitor: compare every presented control vector against the next expectation
  always @(negedge clk) begin
    logic [23:0] got;
    exp_t        e;
    got = {pif.pc_we, pif.pc_sel, pif.ifid_we, pif.ifid_flush, pif.idex_bubble,
           pif.exwb_we, pif.halted, pif.stall_cycles};
    if (fin) begin
      total++;
      if (sb_q.size() != 0) begin
        bad++;
        $display("FAIL drain: %0d expectations never checked, required 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end else if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total++;
      if ((got & e.mask) !== (e.val & e.mask)) begin
        bad++;
        $display("FAIL %s: got=%h required=%h care=%h", e.name, got & e.mask,
                 e.val & e.mask, e.mask);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    chk("reset", norm(0), M_ALL);
    adv();
    rst = 1'b0;
    chk("idle", norm(0), M_ALL);
    adv();

    // RAW on R3: EX match, then WB match (stalls only without forwarding)
    pif.id_valid = 1'b1; pif.id_opcode = OP_ADD; pif.id_use_a = 1'b1; pif.id_sa = 5'd3;
    pif.ex_valid = 1'b1; pif.ex_rw = 1'b1; pif.ex_dr = 5'd3;
    chk("haz_ex", hzd(0), M_ALL);
    adv();
    pif.ex_valid = 1'b0; pif.ex_rw = 1'b0;
    pif.wb_valid = 1'b1; pif.wb_rw = 1'b1; pif.wb_dr = 5'd3;
`ifdef PIPE_CTRL_FWD_EN
    chk("haz_wb_fwd", norm(1), M_ALL);
`else
    chk("haz_wb", hzd(1), M_ALL);
`endif
    adv();
    pif.wb_valid = 1'b0; pif.wb_rw = 1'b0;
    chk("haz_clear", norm(S1), M_ALL);
    adv();
    pif.id_sa = 5'd0; pif.ex_valid = 1'b1; pif.ex_rw = 1'b1; pif.ex_dr = 5'd0;
    pif.wb_valid = 1'b1; pif.wb_rw = 1'b1; pif.wb_dr = 5'd0;
    chk("r0_nohaz", norm(S1), M_ALL);
    adv();
    idle();
    pif.id_valid = 1'b1; pif.id_use_b = 1'b1; pif.id_sb = 5'd7;
    pif.ex_valid = 1'b1; pif.ex_rw = 1'b1; pif.ex_dr = 5'd7;
    chk("haz_b", hzd(S1), M_ALL);
    adv();
    pif.id_use_b = 1'b0;
    chk("mb_imm", norm(S2), M_ALL);
    adv();

    // Branches in EX
    idle();
    pif.ex_valid = 1'b1; pif.ex_bs = BS_COND; pif.ex_ps = 1'b0; pif.ex_zero = 1'b1;
    chk("bz_taken", tkn(PCS_BR, S2), M_TK);
    adv();
    pif.ex_ps = 1'b1;
    chk("bnz_not", norm(S2), M_ALL);
    adv();
    pif.ex_zero = 1'b0;
    chk("bnz_taken", tkn(PCS_BR, S2), M_TK);
    adv();
    pif.ex_bs = BS_JMP;
    chk("jmp", tkn(PCS_JMP, S2), M_TK);
    adv();
    pif.ex_valid = 1'b0; pif.ex_bs = BS_COND; pif.ex_ps = 1'b0; pif.ex_zero = 1'b1;
    chk("br_invalid", norm(S2), M_ALL);
    adv();

    // JMR beats HALT+hazard in DOF; HALT is discarded
    idle();
    pif.ex_valid = 1'b1; pif.ex_bs = BS_REG; pif.ex_rw = 1'b1; pif.ex_dr = 5'd5;
    pif.id_valid = 1'b1; pif.id_opcode = HALT_OP; pif.id_use_a = 1'b1; pif.id_sa = 5'd5;
    chk("jmr_over_halt", tkn(PCS_REG, S2), M_TK);
    adv();
    idle();
    chk("after_jmr", norm(S2), M_ALL);
    adv();

    // LD waiting 3 cycles for memory
    pif.ex_valid = 1'b1; pif.mem_req = 1'b1;
    chk("mem_w1", frz(1'b0, S2), M_FZ);
    adv();
    chk("mem_w2", frz(1'b0, S2 + 1), M_FZ);
    adv();
    chk("mem_w3", frz(1'b0, S2 + 2), M_FZ);
    adv();
    pif.mem_ack = 1'b1;
    chk("mem_ack", norm(S3), M_ALL);
    adv();
    idle();
    chk("mem_done", norm(S3), M_ALL);
    adv();
    pif.ex_valid = 1'b1; pif.mem_req = 1'b1; pif.mem_ack = 1'b1;
    chk("mem_fast", norm(S3), M_ALL);
    adv();

    // HALT drain, hold, resume
    idle();
    pif.id_valid = 1'b1; pif.id_opcode = HALT_OP;
    chk("halt_dof", mk(1'b0, PCS_INC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S3), M_HLT);
    adv();
    idle();
    chk("drain1", mk(1'b0, PCS_INC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S3 + 1), M_DR);
    adv();
    chk("drain2", mk(1'b0, PCS_INC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S3 + 2), M_DR);
    adv();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("halted%0d", i), frz(1'b1, S4), M_FZ);
      adv();
    end
    pif.resume = 1'b1;
    chk("resume", frz(1'b1, S4), M_FZ);
    adv();
    pif.resume = 1'b0;
    chk("first_fetch", norm(S4), M_ALL);
    adv();

    // Reset while waiting on memory
    pif.ex_valid = 1'b1; pif.mem_req = 1'b1;
    chk("rst_w1", frz(1'b0, S4), M_FZ);
    adv();
    rst = 1'b1;
    chk("rst_w2", frz(1'b0, S4 + 1), M_FZ);
    adv();
    rst = 1'b0;
    idle();
    chk("rst_clear", norm(0), M_ALL);
    adv();

    for (int i = 0; i < 8 && sb_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    fin = 1'b1;
  end

endmodule
